muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide engine downstream of the control unit. It receives the two operands and the M-extension operation, computes over multiple cycles, and returns a 32-bit result for register-file writeback. It replaces single-cycle multiply/divide in the ALU path with a start/busy/done handshake. It implements full RISC-V M semantics: signed/unsigned variants, divide-by-zero and signed overflow.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  32  rs1 operand; captured with start.
- b  in  32  rs2 operand; captured with start.
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  high while in CALC or FIN.
- done  out  1  one-cycle pulse; result valid in the same cycle.
- result  out  32  registered result; holds until the next done.

## Operation
- States: IDLE, CALC, FIN.
- IDLE with start=1 does the following:
  - Latch op.
  - Latch |a| and |b| as unsigned magnitudes. A sign is taken only for signed operands: a for MULH, MULHSU, DIV and REM; b for MULH, DIV and REM.
  - Latch the result sign:
    - Product sign = sa XOR sb.
    - Quotient sign = sa XOR sb.
    - Remainder sign = sa.
  - Clear the 6-bit counter.
  - Go to CALC, except for the divide-by-zero fast path (DIV/DIVU/REM/REMU with b=0), which goes directly to FIN.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator. One multiplier bit per cycle, LSB first; 32 iterations.
- CALC, divide: restoring division. The 33-bit partial remainder shifts in one dividend bit per cycle, MSB first; trial-subtract the divisor; the quotient bit is 1 when there is no borrow; 32 iterations.
- CALC leaves to FIN when the counter reaches 31.
- FIN applies the sign fix-up (two's-complement negate when the sign flag is set), selects the output, registers result, asserts done, and returns to IDLE.
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Divide by zero: quotient = 0xFFFFFFFF for both signed and unsigned; remainder = a, unmodified.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of the magnitude path plus negation; no special-casing is needed but it is required behaviour.
- A 0 or 1 divisor has no fast path; it uses the full 32 iterations.
- start while busy is ignored; operands and op are not re-sampled.
- flush=1 in CALC or FIN: next state IDLE, done stays 0, result is unchanged. flush in IDLE has no effect. If flush and start are both high in IDLE, flush wins and the start is dropped.

## Timing
- Reset values, applied asynchronously:
  - Outputs: busy=0, done=0, result=0.
  - Internal: state IDLE, counter 0, accumulator/remainder 0.
- Normal op, with start sampled at edge E0:
  - busy is 1 after E0.
  - Iterations run at E1..E32.
  - E32 enters FIN.
  - E33 registers result; done=1 and busy=0 for the cycle after E33.
  - Latency is 33 cycles start-to-done.
- Divide-by-zero fast path: E0 enters FIN; done after E1, so latency is 1 cycle.
- Back-to-back: start may be asserted in the done cycle, since the state is IDLE. The new operation begins at that edge, and done for the previous operation is not extended.
- done is never high for two consecutive cycles.
- rst asserted mid-operation: immediate return to reset values. No done is produced for the aborted operation.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) -> done exactly 33 cycles after start, result 0xFFFFFFEB. busy is high for cycles 1..33.
- MULH a=b=0x80000000 -> result 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU with the same operands -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF, done 1 cycle after start. REM a=0xFFFFFFF9, b=0 -> 0xFFFFFFF9. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Back-to-back: start in the done cycle of MUL 3*5 (result 15), then DIVU 20/4 -> second done 33 cycles later with result 5. A start pulsed during busy is ignored, and the result is unaffected.
- Abort: flush at cycle 10 of DIV -> busy drops the next cycle, no done, result retains its old value. Async rst at cycle 20 of MUL -> busy/done/result are 0 immediately, and a fresh MUL 2*2 afterwards yields 4.

Source files
------------

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - start/busy/done handshake bundle for the iterative multiply/divide engine
//
// Signals:
//   start  : request, sampled by the engine only when idle
//   op     : RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   : rs1 / rs2 operands, captured with start
//   flush  : abort of the in-flight operation
//   busy   : engine is computing
//   done   : one-cycle pulse, result valid in the same cycle
//   result : registered result, held until the next done
// Modports: master (control unit side), slave (engine side).
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide engine (shift-add multiply, restoring divide)
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : muldiv_if.slave (start/op/a/b/flush in, busy/done/result out)
// Operands are reduced to unsigned magnitudes on start; the sign of the
// result is re-applied in FIN. Both datapaths take 32 CALC cycles, so a
// normal operation completes 33 cycles after start. Divide by zero skips
// CALC and completes one cycle after start.
module muldiv_unit (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  op_r;
  logic        neg_r;    // negate the selected result in FIN
  logic [63:0] acc;      // multiply: {partial product, remaining multiplier}; divide: [31:0] dividend -> quotient
  logic [31:0] rem;      // divide: partial remainder (always < divisor, so 32 bits suffice)
  logic [31:0] divisor;  // |b|: multiplicand or divisor

  // Start-time operand decode
  logic        a_signed, b_signed, sa, sb, is_div, div_zero;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    sa       = a_signed & bus.a[31];
    sb       = b_signed & bus.b[31];
    mag_a    = sa ? -bus.a : bus.a;
    mag_b    = sb ? -bus.b : bus.b;
    is_div   = bus.op[2];
    div_zero = (bus.b == 32'd0);
  end

  // One iteration of each datapath
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_borrow;

  always_comb begin
    mul_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
    div_shift  = {rem, acc[31]};
    div_borrow = (div_shift < {1'b0, divisor});
    // The kept difference is always below the divisor, so modulo-2^32 is exact.
    div_diff   = div_shift[31:0] - divisor;
  end

  // FIN: sign fix-up and output selection
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fin_val;

  always_comb begin
    prod_fix = neg_r ? -acc : acc;
    quo_fix  = neg_r ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_r ? -rem : rem;
    case (op_r)
      3'b000:                 fin_val = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fin_val = prod_fix[63:32];
      3'b100, 3'b101:         fin_val = quo_fix;
      default:                fin_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      op_r       <= 3'd0;
      neg_r      <= 1'b0;
      acc        <= 64'd0;
      rem        <= 32'd0;
      divisor    <= 32'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= 32'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_r     <= bus.op;
            cnt      <= 6'd0;
            divisor  <= mag_b;
            bus.busy <= 1'b1;
            if (is_div && div_zero) begin
              // Quotient all ones (never negated); remainder is |a| re-signed to a.
              acc   <= {32'd0, 32'hFFFF_FFFF};
              rem   <= mag_a;
              neg_r <= bus.op[1] & sa;
              state <= FIN;
            end else begin
              acc   <= {32'd0, mag_a};
              rem   <= 32'd0;
              neg_r <= (is_div && bus.op[1]) ? sa : (sa ^ sb);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            if (op_r[2]) begin
              rem        <= div_borrow ? div_shift[31:0] : div_diff;
              acc[31:0]  <= {acc[30:0], ~div_borrow};
            end else begin
              acc <= {mul_sum, acc[31:1]};
            end
            if (cnt == 6'd31) begin
              state <= FIN;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (!bus.flush) begin
            bus.result <= fin_val;
            bus.done   <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issues one operation from a point 1 time unit after a rising edge,
  // returns latency (edges after the sampling edge; -1 on timeout).
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output bit busy_ok);
    bus.op = o; bus.a = x; bus.b = y; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; res = 32'hDEAD_BEEF; busy_ok = 1'b1;
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = i; res = bus.result;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    n_cmp++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h exp 0", bus.result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_timing();
    int lat; logic [31:0] res; bit bok;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, lat, res, bok);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency got %0d exp 33", lat); end
    n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got %h exp ffffffeb", res); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL mul_busy_window got bad exp high cycles 1..33"); end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_single_cycle got %0b exp 0", bus.done); end
    n_cmp++; if (bus.result !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL result_hold got %h exp ffffffeb", bus.result); end
  endtask

  task automatic test_mul_high();
    int lat; logic [31:0] res; bit bok;
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, lat, res, bok);
    n_cmp++; if (res !== 32'h4000_0000) begin n_err++; $display("FAIL mulh got %h exp 40000000", res); end
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu got %h exp ffffffff", res); end
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu got %h exp fffffffe", res); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] res; bit bok;
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg got %h exp fffffffd", res); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL div_latency got %0d exp 33", lat); end
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_neg got %h exp ffffffff", res); end
    do_op(3'b101, 32'd100, 32'd7, lat, res, bok);
    n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL divu got %h exp e", res); end
    do_op(3'b111, 32'd100, 32'd7, lat, res, bok);
    n_cmp++; if (res !== 32'd2) begin n_err++; $display("FAIL remu got %h exp 2", res); end
    do_op(3'b101, 32'd55, 32'd1, lat, res, bok);
    n_cmp++; if (res !== 32'd55 || lat !== 33) begin n_err++; $display("FAIL divu_by_one got %h lat %0d exp 37 lat 33", res, lat); end
  endtask

  task automatic test_div_edge();
    int lat; logic [31:0] res; bit bok;
    do_op(3'b101, 32'h0000_1234, 32'd0, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu_zero got %h exp ffffffff", res); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL divzero_latency got %0d exp 1", lat); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL divzero_busy got bad exp high one cycle"); end
    do_op(3'b100, 32'hFFFF_FFF9, 32'd0, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_zero_signed got %h exp ffffffff", res); end
    do_op(3'b110, 32'hFFFF_FFF9, 32'd0, lat, res, bok);
    n_cmp++; if (res !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL rem_zero got %h exp fffffff9", res); end
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bok);
    n_cmp++; if (res !== 32'h8000_0000) begin n_err++; $display("FAIL div_overflow got %h exp 80000000", res); end
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bok);
    n_cmp++; if (res !== 32'd0) begin n_err++; $display("FAIL rem_overflow got %h exp 0", res); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; bit bok;
    do_op(3'b000, 32'd3, 32'd5, lat, res, bok);
    n_cmp++; if (res !== 32'd15 || lat !== 33) begin n_err++; $display("FAIL b2b_first got %h lat %0d exp f lat 33", res, lat); end
    // Still in the done cycle: issue the next operation now.
    do_op(3'b101, 32'd20, 32'd4, lat, res, bok);
    n_cmp++; if (res !== 32'd5 || lat !== 33) begin n_err++; $display("FAIL b2b_second got %h lat %0d exp 5 lat 33", res, lat); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL b2b_busy got bad exp continuous busy"); end
    // Start pulse while busy must be ignored.
    bus.op = 3'b101; bus.a = 32'd81; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin bus.op = 3'b000; bus.a = 32'd11; bus.b = 32'd13; bus.start = 1'b1; end
      if (i == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin lat = i; break; end
    end
    n_cmp++; if (bus.result !== 32'd9 || lat !== 33) begin n_err++; $display("FAIL start_while_busy got %h lat %0d exp 9 lat 33", bus.result, lat); end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ignored_start_busy got %0b exp 0", bus.busy); end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res; bit bok; bit saw_done;
    do_op(3'b101, 32'd100, 32'd7, lat, res, bok);
    bus.op = 3'b100; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %0b exp 0", bus.busy); end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_err++; $display("FAIL flush_no_done got done exp none"); end
    n_cmp++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL flush_result_hold got %h exp e", bus.result); end
    // Flush together with start in IDLE drops the start.
    bus.op = 3'b000; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_beats_start got %0b exp 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] res; bit bok;
    bus.op = 3'b000; bus.a = 32'h1234_5678; bus.b = 32'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
      n_err++; $display("FAIL async_reset got busy %0b done %0b result %h exp 0 0 0", bus.busy, bus.done, bus.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(3'b000, 32'd2, 32'd2, lat, res, bok);
    n_cmp++; if (res !== 32'd4 || lat !== 33) begin n_err++; $display("FAIL post_reset_mul got %h lat %0d exp 4 lat 33", res, lat); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_div();
    test_div_edge();
    test_back_to_back();
    test_flush();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
